// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that feeds one registered valid/ready output stage from NUM_REQ streams.
// Define ARB_LOCK_EN to add in_last/out_last and keep a grant locked for a whole packet.
module stream_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       in_valid,
  output logic [NUM_REQ-1:0]       in_ready,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       in_last,
  output logic                     out_last,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [IDW-1:0]           out_id
);

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [IDW-1:0]   out_id_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic [IDW-1:0]   rr_id;
  logic             rr_any;
  logic [IDW-1:0]   idx;
  logic             load;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == IDW'(NUM_REQ - 1)) ? '0 : v + IDW'(1);
  endfunction

  // Reset masks load so no requester sees a handshake that reset would discard.
  assign load = (~out_valid_reg | out_ready) & ~rst;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
      assign gnt[gi]      = gnt_any && (gnt_id == IDW'(gi));
      assign in_ready[gi] = load & gnt[gi];
    end
  endgenerate

  // First valid requester starting at ptr_reg, wrapping past NUM_REQ-1.
  always_comb begin
    rr_any = 1'b0;
    rr_id  = '0;
    idx    = ptr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_any && in_valid[idx]) begin
        rr_any = 1'b1;
        rr_id  = idx;
      end
      idx = wrap_inc(idx);
    end
  end

`ifdef ARB_LOCK_EN
  logic           lock_reg;
  logic [IDW-1:0] lock_id_reg;
  logic           out_last_reg;

  // Mid-packet the grant stays on the locked requester even when it idles.
  always_comb begin
    gnt_any = rr_any;
    gnt_id  = rr_id;
    if (lock_reg) begin
      gnt_any = in_valid[lock_id_reg];
      gnt_id  = lock_id_reg;
    end
  end

  assign out_last = out_last_reg;
`else
  assign gnt_any = rr_any;
  assign gnt_id  = rr_id;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      ptr_reg       <= '0;
`ifdef ARB_LOCK_EN
      lock_reg      <= 1'b0;
      lock_id_reg   <= '0;
      out_last_reg  <= 1'b0;
`endif
    end else if (load) begin
      if (gnt_any) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= data_arr[gnt_id];
        out_id_reg    <= gnt_id;
`ifdef ARB_LOCK_EN
        out_last_reg  <= in_last[gnt_id];
        if (in_last[gnt_id]) begin
          lock_reg <= 1'b0;
          ptr_reg  <= wrap_inc(gnt_id);
        end else begin
          lock_reg    <= 1'b1;
          lock_id_reg <= gnt_id;
        end
`else
        ptr_reg       <= wrap_inc(gnt_id);
`endif
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (NUM_REQ=4, WIDTH=8); lock scenario runs when ARB_LOCK_EN is defined.
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
`ifdef ARB_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  int vectors = 0;
  int miscompares = 0;

  stream_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef ARB_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  // One line per beat that will be handed downstream at the next edge.
  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      $display("beat id=%0d data=%02h", out_id, out_data);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef ARB_LOCK_EN
    in_last   = '1;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
`ifdef ARB_LOCK_EN
    in_last   = 4'b1111;
`endif
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b want=0000", in_ready);
    end
    vectors++;
    if (out_data !== 8'h00 || out_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_out_regs got data=%h id=%0d want data=00 id=0", out_data, out_id);
    end
    rst = 1'b0;
    settle();
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL release_in_ready got=%b want=0001", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'hA0) begin
      miscompares++;
      $display("FAIL first_beat got v=%b id=%0d data=%h want v=1 id=0 data=a0", out_valid, out_id, out_data);
    end
    // Reset with a beat stalled in the output register discards it.
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midflight got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_id [5];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    in_valid = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_id !== exp_id[k] || out_data !== 8'hA0 + 8'(exp_id[k])) begin
        miscompares++;
        $display("FAIL rr_beat%0d got v=%b id=%0d data=%h want v=1 id=%0d data=%h",
                 k, out_valid, out_id, out_data, exp_id[k], 8'hA0 + 8'(exp_id[k]));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] beats [3];
    beats = '{8'h11, 8'h22, 8'h33};
    do_reset();
    in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      in_data[2*W +: W] = beats[k];
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== beats[k]) begin
        miscompares++;
        $display("FAIL lone_beat%0d got v=%b id=%0d data=%h want v=1 id=2 data=%h",
                 k, out_valid, out_id, out_data, beats[k]);
      end
    end
    in_valid = 4'b0000;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h33) begin
      miscompares++;
      $display("FAIL lone_drain got v=%b data=%h want v=0 data=33", out_valid, out_data);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    in_data[1*W +: W] = 8'h55;
    tick();
    in_data[1*W +: W] = 8'h66;
    for (int k = 0; k < 3; k++) begin
      settle();
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL stall_in_ready%0d got=%b want=0000", k, in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h55) begin
        miscompares++;
        $display("FAIL stall_hold%0d got v=%b data=%h want v=1 data=55", k, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    settle();
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL drain_in_ready got=%b want=0010", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 8'h66) begin
      miscompares++;
      $display("FAIL drain_beat got v=%b id=%0d data=%h want v=1 id=1 data=66", out_valid, out_id, out_data);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    in_valid = 4'b0100;
    in_data[2*W +: W] = 8'hC2;
    tick();
    in_valid = 4'b1001;
    in_data[0*W +: W] = 8'hC0;
    in_data[3*W +: W] = 8'hC3;
    settle();
    vectors++;
    if (in_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_ready3 got=%b want=1000", in_ready);
    end
    tick();
    vectors++;
    if (out_id !== 2'd3 || out_data !== 8'hC3) begin
      miscompares++;
      $display("FAIL wrap_beat3 got id=%0d data=%h want id=3 data=c3", out_id, out_data);
    end
    settle();
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_ready0 got=%b want=0001", in_ready);
    end
    tick();
    vectors++;
    if (out_id !== 2'd0 || out_data !== 8'hC0) begin
      miscompares++;
      $display("FAIL wrap_beat0 got id=%0d data=%h want id=0 data=c0", out_id, out_data);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock;
    logic [7:0] beats [3];
    beats = '{8'hB1, 8'hB2, 8'hB3};
    do_reset();
    in_valid = 4'b0001;
    in_last  = 4'b1111;
    in_data[0*W +: W] = 8'h0F;
    tick();
    in_valid = 4'b0011;
    in_data[0*W +: W] = 8'h10;
    for (int k = 0; k < 3; k++) begin
      in_data[1*W +: W] = beats[k];
      in_last[1] = (k == 2);
      settle();
      vectors++;
      if (in_ready !== 4'b0010) begin
        miscompares++;
        $display("FAIL lock_ready%0d got=%b want=0010", k, in_ready);
      end
      tick();
      vectors++;
      if (out_id !== 2'd1 || out_data !== beats[k] || out_last !== (k == 2)) begin
        miscompares++;
        $display("FAIL lock_beat%0d got id=%0d data=%h last=%b want id=1 data=%h last=%b",
                 k, out_id, out_data, out_last, beats[k], (k == 2));
      end
    end
    in_valid = 4'b0001;
    settle();
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL unlock_ready got=%b want=0001", in_ready);
    end
    tick();
    vectors++;
    if (out_id !== 2'd0 || out_data !== 8'h10 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL unlock_beat got id=%0d data=%h last=%b want id=0 data=10 last=1", out_id, out_data, out_last);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    in_last   = '0;
`endif
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_wrap();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
